// File: rtl/btn_step_pkg.sv
// Shared FSM encoding and parameter floors for the button step generator.
// Out-of-range cycle parameters are clamped up to the smallest legal value.
package btn_step_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_REPEAT  = 2'd2;

  localparam int MIN_DEBOUNCE_CYCLES = 2;
  localparam int MIN_HOLD_CYCLES     = 2;
  localparam int MIN_REPEAT_CYCLES   = 2;

  function automatic int clamp_min(input int value, input int floor_val);
    return (value < floor_val) ? floor_val : value;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer plus stable-run counter; btn_level follows the
// synchronized button only after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_sync
  import btn_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_async,
  output logic o_btn_level
);

  localparam int DB_C = clamp_min(DEBOUNCE_CYCLES, MIN_DEBOUNCE_CYCLES);
  localparam int CW   = $clog2(DB_C) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_C - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn_async;
      r_s2 <= r_s1;
    end
  end

  // Toggle on the edge that would take the count to DB_C, so the level
  // moves exactly DB_C edges after the first differing s2 sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_s2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_level <= ~r_level;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_btn_level = r_level;

endmodule

// File: rtl/button_step_gen.sv
// Turns a bouncing push-button into clean one-cycle step pulses, with an
// optional hold-to-repeat mode; all outputs are registered.
module button_step_gen
  import btn_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic repeat_en,
  output logic step,
  output logic btn_level,
  output logic repeating
);

  localparam int HOLD_C = clamp_min(HOLD_CYCLES, MIN_HOLD_CYCLES);
  localparam int REP_C  = clamp_min(REPEAT_CYCLES, MIN_REPEAT_CYCLES);
  localparam int HOLD_W = $clog2(HOLD_C) + 1;
  localparam int REP_W  = $clog2(REP_C) + 1;
  localparam int TW     = (HOLD_W > REP_W) ? HOLD_W : REP_W;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_C - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REP_C - 1);

  logic          w_level;
  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic          r_step;
  logic          r_repeating;
  logic          w_step_nxt;
  logic          w_repeating_nxt;

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_btn_async (btn_in),
    .o_btn_level (w_level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_step      <= 1'b0;
      r_repeating <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_step      <= w_step_nxt;
      r_repeating <= w_repeating_nxt;
    end
  end

  // Release is tested first in every state so it always beats a due pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      ST_IDLE: begin
        if (w_level) begin
          w_state_nxt = ST_PRESSED;
          w_timer_nxt = '0;
        end
      end
      ST_PRESSED: begin
        if (!w_level) begin
          w_state_nxt = ST_IDLE;
        end else if (r_timer == HOLD_LAST) begin
          if (repeat_en) begin
            w_state_nxt = ST_REPEAT;
            w_timer_nxt = '0;
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      ST_REPEAT: begin
        if (!w_level) begin
          w_state_nxt = ST_IDLE;
        end else if (!repeat_en) begin
          w_state_nxt = ST_PRESSED;
          w_timer_nxt = '0;
        end else if (r_timer == REP_LAST) begin
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_step_nxt = 1'b0;
    if (w_level) begin
      case (r_state)
        ST_IDLE:    w_step_nxt = 1'b1;
        ST_PRESSED: w_step_nxt = repeat_en && (r_timer == HOLD_LAST);
        ST_REPEAT:  w_step_nxt = repeat_en && (r_timer == REP_LAST);
        default:    w_step_nxt = 1'b0;
      endcase
    end
    w_repeating_nxt = (w_state_nxt == ST_REPEAT);
  end

  assign step      = r_step;
  assign btn_level = w_level;
  assign repeating = r_repeating;

endmodule

// File: tb/tb_button_step_gen.sv
// Randomized and directed bench for button_step_gen against an edge-count
// reference model; a mod-8 step counter stands in for counter_mod8.
module tb_button_step_gen;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 5;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic repeat_en;
  logic step;
  logic btn_level;
  logic repeating;

  button_step_gen #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .repeat_en (repeat_en),
    .step      (step),
    .btn_level (btn_level),
    .repeating (repeating)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_steps = 0;
  int cnt8    = 0;
  int first_step = -1;

  // Reference model: btn samples per edge, debounced level, press phase
  // (0 idle, 1 held, 2 repeating) and the edge of the last timing reference.
  bit q[$];
  bit m_lvl;
  bit m_step;
  bit m_rep;
  int m_phase;
  int m_ref;
  int m_edge;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i <= D; i++) q.push_back(1'b0);
    m_lvl = 0; m_step = 0; m_rep = 0; m_phase = 0; m_ref = 0; m_edge = 0;
  endtask

  task automatic model_edge(input bit b, input bit ren);
    bit lvl_seen;
    bit all_diff;
    lvl_seen = m_lvl;
    m_step = 0;
    if (!lvl_seen) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      m_step = 1; m_phase = 1; m_ref = m_edge;
    end else if (m_phase == 1) begin
      if (ren && (m_edge - m_ref >= H)) begin
        m_step = 1; m_phase = 2; m_ref = m_edge;
      end
    end else begin
      if (!ren) begin
        m_phase = 1; m_ref = m_edge;
      end else if (m_edge - m_ref == R) begin
        m_step = 1; m_ref = m_edge;
      end
    end
    m_rep = (m_phase == 2);
    // Level flips once the last D synchronized samples all disagree with it.
    all_diff = 1;
    for (int j = 1; j <= D; j++) if (q[j] == lvl_seen) all_diff = 0;
    if (all_diff) m_lvl = !m_lvl;
    q.push_front(b);
    void'(q.pop_back());
    m_edge++;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (reset) model_edge(btn_in, repeat_en);
    #1;
    check("step", step, m_step);
    check("btn_level", btn_level, m_lvl);
    check("repeating", repeating, m_rep);
    if (step) begin
      n_steps++;
      cnt8 = (cnt8 + 1) % 8;
      if (first_step < 0) first_step = cyc;
    end
  endtask

  task automatic drive(input bit b, input bit ren, input int n);
    btn_in = b;
    repeat_en = ren;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called at posedge+1; asserts reset at the following negedge.
  task automatic async_reset(input int hold);
    #4;
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_step", step, 1'b0);
    check("rst_level", btn_level, 1'b0);
    check("rst_repeating", repeating, 1'b0);
    for (int i = 0; i < hold; i++) tick();
    reset = 1'b1;
  endtask

  initial begin
    int k;
    int s0;
    int c0;
    bit b;
    bit ren;

    reset = 1'b0; btn_in = 1'b1; repeat_en = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    check("reset_count", cnt8, 0);
    reset = 1'b1;
    drive(0, 0, 10);

    // Clean press without repeat: one step, D+2 edges after first high sample.
    first_step = -1;
    s0 = n_steps;
    k = cyc + 1;
    drive(1, 0, 30);
    drive(0, 0, 20);
    check("press_latency", first_step - k, D + 2);
    check("press_steps", n_steps - s0, 1);
    check("press_count", cnt8, 1);

    // Bounce shorter than the debounce window.
    s0 = n_steps;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 2);
      drive(0, 0, 2);
    end
    drive(0, 0, 20);
    check("bounce_steps", n_steps - s0, 0);
    check("bounce_count", cnt8, 1);

    // Auto-repeat: 50 cycles held gives initial + 6 repeats, release wins.
    s0 = n_steps;
    drive(1, 1, 50);
    drive(0, 1, 20);
    check("repeat_steps", n_steps - s0, 7);

    // Reset while repeating, button still held through release.
    drive(1, 1, 35);
    check("in_repeat", repeating, 1'b1);
    async_reset(3);
    s0 = n_steps;
    drive(1, 1, 30);
    check("post_reset_steps", n_steps - s0, 2);
    drive(0, 1, 20);

    // Nine discrete presses wrap the mod-8 counter.
    s0 = n_steps;
    c0 = cnt8;
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 10);
      drive(0, 0, 10);
    end
    check("wrap_steps", n_steps - s0, 9);
    check("wrap_count", cnt8, (c0 + 9) % 8);

    // Random runs: bounces, long holds, repeat_en flips, occasional resets.
    b = 0;
    ren = 0;
    for (int s = 0; s < 160; s++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 45);
      if ($urandom_range(0, 5) == 0) ren = ~ren;
      b = ~b;
      drive(b, ren, len);
      if ($urandom_range(0, 40) == 0) async_reset($urandom_range(1, 4));
    end
    drive(0, 0, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
